// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
//   AHB slave-port bundle between the interconnect (master side) and an
//   AHB responder (slave side).
//
//   Handshake: an address phase is taken on a rising HCLK edge when
//   HSEL & HREADY & HTRANS[1] are all high. The data phase that follows ends
//   on the first rising edge at which the slave drives HREADYOUT high. HWDATA
//   belongs to the data phase. HRDATA/HRESP are valid while HREADYOUT is high.
//
//   master modport: drives HSEL/HTRANS/HSIZE/HADDR/HWRITE/HWDATA/HREADY,
//                   observes HREADYOUT/HRESP/HRDATA/HSPLIT
//   slave  modport: the mirror image
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if #(
  parameter int W_ADDR   = 32,
  parameter int W_DATA   = 32,
  parameter int N_MASTER = 3
);
  logic                HSEL;
  logic [1:0]          HTRANS;
  logic [2:0]          HSIZE;
  logic [W_ADDR-1:0]   HADDR;
  logic                HWRITE;
  logic [W_DATA-1:0]   HWDATA;
  logic                HREADY;
  logic                HREADYOUT;
  logic [1:0]          HRESP;
  logic [W_DATA-1:0]   HRDATA;
  logic [N_MASTER-1:0] HSPLIT;

  modport master (
    output HSEL, HTRANS, HSIZE, HADDR, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA, HSPLIT
  );

  modport slave (
    input  HSEL, HTRANS, HSIZE, HADDR, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA, HSPLIT
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB responder backed by a word-organised flop-array memory. Supports
//   programmable wait states and little-endian byte/halfword/word writes.
//
//   Ports:
//     HCLK        in   bus clock, rising edge
//     HRESETn     in   asynchronous reset, active-low
//     bus         ahb_sram_slave_if.slave (HSEL, HTRANS, HSIZE, HADDR, HWRITE,
//                 HWDATA, HREADY in; HREADYOUT, HRESP, HRDATA, HSPLIT out)
//     o_dbg_state out  current FSM state (IDLE=0 WAIT=1 DATA=2 ERR1=3 ERR2=4)
//
//   Build option: AHB_SLV_ERR_EN
//     defined   - oversize, misaligned or out-of-range transfers get the
//                 two-cycle ERROR response and never touch memory.
//     undefined - no ERROR; size >word is treated as word, the address is
//                 aligned down to the size and the word index wraps.
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 0,
  parameter int N_MASTER    = 3
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_sram_slave_if.slave       bus,
  output logic [2:0]            o_dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [3:0]        r_cnt;
  logic [AW+1:0]     r_addr;
  logic [1:0]        r_size;
  logic              r_write;
  logic              r_err;
  logic [W_DATA-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_err;
  logic [1:0]        w_size;
  logic [W_ADDR-1:0] w_addr;
  logic [3:0]        w_be;
  logic [AW-1:0]     w_idx;
  logic              w_unused;

  // Bus HREADY is low in WAIT/ERR1 anyway; the local term keeps the slave
  // safe if it is ever wired to a bus that does not loop HREADYOUT back.
  assign w_ready  = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & w_ready;

`ifdef AHB_SLV_ERR_EN
  always_comb begin
    w_size = bus.HSIZE[1:0];
    w_addr = bus.HADDR;
    w_err  = (bus.HSIZE > 3'b010)
          || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
          || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00))
          || ({2'b00, bus.HADDR[W_ADDR-1:2]} >= W_ADDR'(DEPTH));
  end
  assign w_unused = bus.HTRANS[0];
`else
  // Oversize becomes word; low address bits are forced to size alignment.
  always_comb begin
    w_size = (bus.HSIZE > 3'b010) ? 2'b10 : bus.HSIZE[1:0];
    w_addr = bus.HADDR;
    case (w_size)
      2'b01:   w_addr[0]   = 1'b0;
      2'b10:   w_addr[1:0] = 2'b00;
      default: ;
    endcase
    w_err = 1'b0;
  end
  // Upper address bits are dropped: the word index wraps modulo DEPTH.
  assign w_unused = bus.HTRANS[0] ^ (^bus.HADDR[W_ADDR-1:AW+2]);
`endif

  assign w_idx = r_addr[AW+1:2];

  // Little-endian lane enables for the registered transfer.
  always_comb begin
    case (r_size)
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // IDLE, DATA and ERR2 all take a new address phase the same way, which
  // gives back-to-back transfers with no bubble.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: if (r_cnt <= 4'd1) w_next = S_DATA;
      S_ERR1: w_next = S_ERR2;
      default: begin
        if (!w_accept)            w_next = S_IDLE;
        else if (w_err)           w_next = S_ERR1;
        else if (WAIT_STATES > 0) w_next = S_WAIT;
        else                      w_next = S_DATA;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= w_addr[AW+1:0];
        r_size  <= w_size;
        r_write <= bus.HWRITE;
        r_err   <= w_err;
      end
      if (w_accept && !w_err)  r_cnt <= WS;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Write commits on the edge that ends DATA. Reset forces IDLE at once,
  // so a write whose data phase has not completed is dropped.
  always_ff @(posedge HCLK) begin
    if ((r_state == S_DATA) && r_write && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = w_ready;
  assign bus.HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
  assign bus.HRDATA    = (((r_state == S_WAIT) || (r_state == S_DATA)) && !r_write && !r_err)
                         ? r_mem[w_idx] : '0;
  assign bus.HSPLIT    = '0;
  assign o_dbg_state   = r_state;

endmodule
